// File: rtl/multi_push_fifo_if.sv
// multi_push_fifo_if: push/pop handshake bundle between flow control, the issue queue and its consumer.
interface multi_push_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PUSH_PORTS = 2,
    parameter int POP_PORTS  = 2
);
    logic                                  flush;
    logic [PUSH_PORTS-1:0]                 push;
    logic [PUSH_PORTS-1:0][DATA_WIDTH-1:0] data_in;
    logic [PUSH_PORTS-1:0]                 ready_out;
    logic [POP_PORTS-1:0]                  valid_out;
    logic [POP_PORTS-1:0][DATA_WIDTH-1:0]  data_out;
    logic [POP_PORTS-1:0]                  pop;

    modport master(output flush, push, data_in, pop, input ready_out, valid_out, data_out);
    modport slave(input flush, push, data_in, pop, output ready_out, valid_out, data_out);
endinterface

// File: rtl/multi_push_fifo.sv
// multi_push_fifo: circular issue queue with compacting multi-port push and in-order prefix pop.
module multi_push_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int PUSH_PORTS = 2,
    parameter int POP_PORTS  = 2
) (
    input logic               clk,
    input logic               rst,
    multi_push_fifo_if.slave  fifo_io
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]         mem_q [DEPTH];
    logic [AW-1:0]                 head_q, head_d, tail_q, tail_d;
    logic [AW:0]                   count_q, count_d, free, acc, rcnt;
    logic [PUSH_PORTS-1:0]         wen;
    logic [PUSH_PORTS-1:0][AW-1:0] waddr;
    logic                          alive;

    assign free = (AW+1)'(DEPTH) - count_q;

    // Asserted push ports are packed onto consecutive slots; those past the free space drop out.
    always_comb begin
        acc   = '0;
        wen   = '0;
        waddr = '0;
        for (int k = 0; k < PUSH_PORTS; k++) begin
            waddr[k] = tail_q + acc[AW-1:0];
            wen[k]   = fifo_io.push[k] && (acc < free);
            acc      = acc + (AW+1)'(wen[k]);
        end
        rcnt  = '0;
        alive = 1'b1;
        for (int j = 0; j < POP_PORTS; j++) begin
            alive = alive && fifo_io.pop[j] && (count_q > (AW+1)'(j));
            rcnt  = rcnt + (AW+1)'(alive);
        end
        tail_d  = tail_q + acc[AW-1:0];
        head_d  = head_q + rcnt[AW-1:0];
        count_d = count_q + acc - rcnt;
    end

    always_ff @(posedge clk) begin
        if (rst || fifo_io.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH_PORTS; k++)
            if (!rst && !fifo_io.flush && wen[k]) mem_q[waddr[k]] <= fifo_io.data_in[k];
    end

    for (genvar j = 0; j < POP_PORTS; j++) begin : g_pop
        assign fifo_io.valid_out[j] = count_q > (AW+1)'(j);
        assign fifo_io.data_out[j]  = (count_q > (AW+1)'(j)) ? mem_q[head_q + AW'(j)] : '0;
    end

    for (genvar k = 0; k < PUSH_PORTS; k++) begin : g_push
        assign fifo_io.ready_out[k] = free > (AW+1)'(k);
    end
endmodule
